time_set_controller: RTL and testbench

- Upstream time-keeping stage for the 50 MHz board clock design. It owns the 24-hour hours/minutes/seconds registers and advances them on a 1 Hz enable.
- Two push-buttons let the user enter a set mode and adjust hours and minutes.
- Outputs are binary hour/min/sec plus per-field blanking flags, which the seven-segment digit-split/decode stage consumes directly.
- Everything runs on one clock domain with clock enables; no derived clocks.

---
 rtl/clock_pkg.sv | 23 ++
 rtl/time_set_controller_if.sv | 29 ++
 rtl/key_debounce.sv | 61 ++++++
 rtl/time_set_controller.sv | 169 ++++++++++++++++
 tb/tb_time_set_controller.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the time-keeping and set-mode logic.
//   mode_t       : controller state, also driven out as the 2-bit mode code
//   *_MAX        : last legal value of each time field
//   cnt_width()  : bit width for a counter that holds 0..n-1
package clock_pkg;

    localparam int CLK_FREQ_HZ = 50_000_000;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_t;

    localparam logic [4:0] HOUR_MAX = 5'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] SEC_MAX  = 6'd59;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Signal bundle between the time/set controller and its environment.
//   tick_1hz, key_mode_n, key_inc_n : stimulus into the controller
//   hour, min, sec                  : binary time fields
//   mode                            : 0 RUN, 1 SET_HOUR, 2 SET_MIN
//   blank_hr, blank_min             : per-field blanking for the display stage
// master = environment side, slave = controller side.
interface time_set_controller_if;

    logic       tick_1hz;
    logic       key_mode_n;
    logic       key_inc_n;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] mode;
    logic       blank_hr;
    logic       blank_min;

    modport master (
        output tick_1hz, key_mode_n, key_inc_n,
        input  hour, min, sec, mode, blank_hr, blank_min
    );

    modport slave (
        input  tick_1hz, key_mode_n, key_inc_n,
        output hour, min, sec, mode, blank_hr, blank_min
    );

endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter, press pulse.
//   clk, rst : clock and async active-high reset
//   key_n    : raw active-low button
//   pressed  : debounced level, 1 = held
//   press    : one-cycle pulse on debounced released->pressed
module key_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed,
    output logic press
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          armed;
    logic          level;
    logic          sample;
    logic [CW-1:0] cnt;

    // A key held through reset must be seen released once before it can
    // register, so the synchronizer resets to "pressed" and the debouncer only
    // accepts a pressed sample after a released one has been observed.
    assign sample = sync_b & armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a  <= 1'b1;
            sync_b  <= 1'b1;
            armed   <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            pressed <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_a <= ~key_n;
            sync_b <= sync_a;
            if (!sync_b) begin
                armed <= 1'b1;
            end
            if (sample == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sample;
            end else begin
                cnt <= cnt + 1'b1;
            end
            pressed <= level;
            press   <= level & ~pressed;
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// 24-hour time keeper with two-button set mode, auto-repeat and field blink.
//   CLOCK_50 : system clock
//   rst      : async active-high reset
//   bus      : tick/keys in, hour/min/sec/mode/blank flags out (all registered)
module time_set_controller
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY_CYCLES = 25_000_000,
    parameter int REPEAT_RATE_CYCLES  = 5_000_000,
    parameter int BLINK_HALF_CYCLES   = 12_500_000
) (
    input  logic                  CLOCK_50,
    input  logic                  rst,
    time_set_controller_if.slave  bus
);

    localparam int RPT_SPAN = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                              REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int RW = cnt_width(RPT_SPAN);
    localparam int BW = cnt_width(BLINK_HALF_CYCLES);
    localparam logic [RW-1:0] RPT_DELAY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RPT_RATE_LAST  = RW'(REPEAT_RATE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST     = BW'(BLINK_HALF_CYCLES - 1);

    logic          mode_press;
    logic          unused_mode_held;
    logic          inc_press;
    logic          inc_held;
    logic          rpt_pulse;
    logic          inc_evt;
    logic [RW-1:0] rpt_cnt;

    mode_t         state_q, state_next;
    logic [4:0]    hour_q, hour_next;
    logic [5:0]    min_q, min_next;
    logic [5:0]    sec_q, sec_next;
    logic [BW-1:0] blink_cnt_q, blink_cnt_next;
    logic          phase_q, phase_next;
    logic          blank_hr_q, blank_min_q;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
        .clk     (CLOCK_50),
        .rst     (rst),
        .key_n   (bus.key_mode_n),
        .pressed (unused_mode_held),
        .press   (mode_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
        .clk     (CLOCK_50),
        .rst     (rst),
        .key_n   (bus.key_inc_n),
        .pressed (inc_held),
        .press   (inc_press)
    );

    // Hold timer: loaded on press, fires when it reaches zero, then reloads
    // with the repeat period for as long as the key stays held.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            rpt_cnt <= '0;
        end else if (!inc_held) begin
            rpt_cnt <= '0;
        end else if (inc_press) begin
            rpt_cnt <= RPT_DELAY_LAST;
        end else if (rpt_cnt == '0) begin
            rpt_cnt <= RPT_RATE_LAST;
        end else begin
            rpt_cnt <= rpt_cnt - 1'b1;
        end
    end

    assign rpt_pulse = inc_held & ~inc_press & (rpt_cnt == '0);
    assign inc_evt   = inc_press | rpt_pulse;

    always_comb begin
        state_next     = state_q;
        hour_next      = hour_q;
        min_next       = min_q;
        sec_next       = sec_q;
        blink_cnt_next = blink_cnt_q;
        phase_next     = phase_q;

        // A mode press always takes priority: any tick or inc in the same
        // cycle is dropped.
        case (state_q)
            MODE_RUN: begin
                if (mode_press) begin
                    state_next = MODE_SET_HOUR;
                end else if (bus.tick_1hz) begin
                    if (sec_q == SEC_MAX) begin
                        sec_next = '0;
                        if (min_q == MIN_MAX) begin
                            min_next  = '0;
                            hour_next = (hour_q == HOUR_MAX) ? '0 : hour_q + 1'b1;
                        end else begin
                            min_next = min_q + 1'b1;
                        end
                    end else begin
                        sec_next = sec_q + 1'b1;
                    end
                end
            end
            MODE_SET_HOUR: begin
                if (mode_press) begin
                    state_next = MODE_SET_MIN;
                end else if (inc_evt) begin
                    hour_next = (hour_q == HOUR_MAX) ? '0 : hour_q + 1'b1;
                end
            end
            MODE_SET_MIN: begin
                if (mode_press) begin
                    state_next = MODE_RUN;
                    sec_next   = '0;
                end else if (inc_evt) begin
                    min_next = (min_q == MIN_MAX) ? '0 : min_q + 1'b1;
                end
            end
            default: begin
                state_next = MODE_RUN;
            end
        endcase

        // Edited field is shown solid on entry and right after every inc.
        if (state_next == MODE_RUN) begin
            blink_cnt_next = '0;
            phase_next     = 1'b0;
        end else if ((state_next != state_q) || inc_evt) begin
            blink_cnt_next = BLINK_LAST;
            phase_next     = 1'b0;
        end else if (blink_cnt_q == '0) begin
            blink_cnt_next = BLINK_LAST;
            phase_next     = ~phase_q;
        end else begin
            blink_cnt_next = blink_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q     <= MODE_RUN;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            blank_hr_q  <= 1'b0;
            blank_min_q <= 1'b0;
        end else begin
            state_q     <= state_next;
            hour_q      <= hour_next;
            min_q       <= min_next;
            sec_q       <= sec_next;
            blink_cnt_q <= blink_cnt_next;
            phase_q     <= phase_next;
            blank_hr_q  <= (state_next == MODE_SET_HOUR) & phase_next;
            blank_min_q <= (state_next == MODE_SET_MIN) & phase_next;
        end
    end

    assign bus.hour      = hour_q;
    assign bus.min       = min_q;
    assign bus.sec       = sec_q;
    assign bus.mode      = state_q;
    assign bus.blank_hr  = blank_hr_q;
    assign bus.blank_min = blank_min_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed + randomized bench for time_set_controller with short timing
// parameters. The reference model keeps time as a seconds-of-day count.
module tb_time_set_controller;

    logic CLOCK_50;
    logic rst;

    time_set_controller_if bus ();

    time_set_controller #(
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_DELAY_CYCLES (20),
        .REPEAT_RATE_CYCLES  (5),
        .BLINK_HALF_CYCLES   (8)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .bus      (bus.slave)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_asserts = 0;
    int n_fail    = 0;
    int m_mode    = 0;
    int m_secs    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic check_time(input string tag);
        chk({tag, ".hour"}, 32'(bus.hour), 32'(m_secs / 3600));
        chk({tag, ".min"},  32'(bus.min),  32'((m_secs / 60) % 60));
        chk({tag, ".sec"},  32'(bus.sec),  32'(m_secs % 60));
        chk({tag, ".mode"}, 32'(bus.mode), 32'(m_mode));
    endtask

    task automatic model_inc();
        int h, mi, s;
        h  = m_secs / 3600;
        mi = (m_secs / 60) % 60;
        s  = m_secs % 60;
        if (m_mode == 1) h  = (h + 1) % 24;
        if (m_mode == 2) mi = (mi + 1) % 60;
        m_secs = h * 3600 + mi * 60 + s;
    endtask

    task automatic model_mode();
        if (m_mode == 2) m_secs = m_secs - (m_secs % 60);
        m_mode = (m_mode + 1) % 3;
    endtask

    // Press one or both keys cleanly, short enough to never auto-repeat.
    task automatic press(input bit do_mode, input bit do_inc);
        @(negedge CLOCK_50);
        if (do_mode) bus.key_mode_n = 1'b0;
        if (do_inc)  bus.key_inc_n  = 1'b0;
        step(10);
        if (do_mode) bus.key_mode_n = 1'b1;
        if (do_inc)  bus.key_inc_n  = 1'b1;
        step(12);
        if (do_mode)     model_mode();
        else if (do_inc) model_inc();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK_50);
            bus.tick_1hz = 1'b1;
            @(negedge CLOCK_50);
            bus.tick_1hz = 1'b0;
            if (m_mode == 0) m_secs = (m_secs + 1) % 86400;
        end
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        m_mode = 0;
        m_secs = 0;
    endtask

    // Minutes seen after k cycles of a continuous hold in SET_MIN from 0:
    // one at the press, then repeats at 20, 25, 30 ... cycles, stopping at 40.
    function automatic int rep_min(input int k);
        int c;
        c = (k >= 1) ? 1 : 0;
        for (int t = 20; t < 40; t += 5)
            if (t < k) c++;
        return c;
    endfunction

    initial begin
        logic glitch [14];
        int   n;

        rst            = 1'b1;
        bus.tick_1hz   = 1'b0;
        bus.key_mode_n = 1'b1;
        bus.key_inc_n  = 1'b1;
        step(3);
        check_time("reset");
        chk("reset.blank_hr",  32'(bus.blank_hr),  0);
        chk("reset.blank_min", 32'(bus.blank_min), 0);
        rst = 1'b0;
        step(2);

        // Glitchy mode key: no low run long enough to register.
        glitch = '{0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1};
        foreach (glitch[i]) begin
            @(negedge CLOCK_50);
            bus.key_mode_n = glitch[i];
        end
        step(4);
        check_time("glitch");

        // Clean press: mode steps exactly at DEBOUNCE+3 (+1 for the register),
        // then the hour field blinks with an 8-cycle half period.
        @(negedge CLOCK_50);
        bus.key_mode_n = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge CLOCK_50);
            if (k == 7)  chk("latency.before", 32'(bus.mode), 0);
            if (k == 8)  chk("latency.step",   32'(bus.mode), 1);
            if (k == 10) bus.key_mode_n = 1'b1;
            if (k >= 8) begin
                chk("blink.hr",  32'(bus.blank_hr),  32'(((k - 8) / 8) % 2));
                chk("blink.min", 32'(bus.blank_min), 0);
            end
        end
        m_mode = 1;
        check_time("set_hour_entry");

        // Inc restarts the blink with the field visible.
        bus.key_inc_n = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLOCK_50);
            if (k == 8) begin
                chk("blink_inc.hr_vis", 32'(bus.blank_hr), 0);
                chk("blink_inc.hour",   32'(bus.hour),     1);
            end
            if (k == 15) chk("blink_inc.hold", 32'(bus.blank_hr), 0);
            if (k == 16) chk("blink_inc.flip", 32'(bus.blank_hr), 1);
        end
        bus.key_inc_n = 1'b1;
        step(12);
        model_inc();
        check_time("after_blink");

        // Mode and inc together: mode wins.
        press(1, 1);
        check_time("simultaneous");
        press(1, 0);
        check_time("back_to_run");

        // Set flow with ticks ignored while editing.
        do_reset();
        press(1, 0);
        tick($urandom_range(1, 3));
        for (int i = 0; i < 5; i++) press(0, 1);
        press(1, 0);
        tick($urandom_range(1, 3));
        for (int i = 0; i < 61; i++) press(0, 1);
        press(1, 0);
        check_time("set_flow");
        chk("set_flow.hour", 32'(bus.hour), 5);
        chk("set_flow.min",  32'(bus.min),  1);
        tick($urandom_range(3, 12));
        check_time("set_flow_run");

        // Auto-repeat in SET_MIN from 0.
        do_reset();
        press(1, 0);
        press(1, 0);
        check_time("repeat_entry");
        @(negedge CLOCK_50);
        bus.key_inc_n = 1'b0;
        step(7);
        for (int k = 1; k <= 33; k++) begin
            @(negedge CLOCK_50);
            chk($sformatf("repeat.k%0d", k), 32'(bus.min), 32'(rep_min(k)));
        end
        bus.key_inc_n = 1'b1;
        step(20);
        chk("repeat.final", 32'(bus.min), 5);
        m_secs = 5 * 60;
        check_time("repeat_release");

        // Async reset mid-hold.
        @(negedge CLOCK_50);
        bus.key_inc_n = 1'b0;
        step($urandom_range(8, 30));
        rst = 1'b1;
        #1;
        chk("async_rst.hour",  32'(bus.hour),      0);
        chk("async_rst.min",   32'(bus.min),       0);
        chk("async_rst.sec",   32'(bus.sec),       0);
        chk("async_rst.mode",  32'(bus.mode),      0);
        chk("async_rst.blank", 32'({bus.blank_hr, bus.blank_min}), 0);
        step(2);
        rst = 1'b0;
        m_mode = 0;
        m_secs = 0;
        press(1, 0);
        press(1, 0);
        step(40);
        check_time("held_after_rst");
        bus.key_inc_n = 1'b1;
        step(12);
        check_time("released_after_rst");
        press(0, 1);
        check_time("repress_after_rst");

        // Rollover from 23:59:58.
        do_reset();
        press(1, 0);
        for (int i = 0; i < 23; i++) press(0, 1);
        press(1, 0);
        for (int i = 0; i < 59; i++) press(0, 1);
        press(1, 0);
        tick(58);
        check_time("preload");
        tick(1);
        check_time("rollover_59");
        tick(1);
        check_time("rollover_00");

        // Random edits and run periods.
        for (int r = 0; r < 3; r++) begin
            press(1, 0);
            n = $urandom_range(0, 25);
            for (int i = 0; i < n; i++) press(0, 1);
            press(1, 0);
            n = $urandom_range(0, 25);
            for (int i = 0; i < n; i++) press(0, 1);
            tick($urandom_range(0, 2));
            press(1, 0);
            check_time($sformatf("rand_set%0d", r));
            tick($urandom_range(1, 150));
            check_time($sformatf("rand_run%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
